// File: rtl/serial_sub.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : serial_sub
// Description : Bit-serial unsigned subtractor, diff = a - b, LSB first, one
//               bit per clock with a registered borrow. start/busy/done
//               handshake for a controlling FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int C_CNT_W = $clog2(WIDTH + 1);
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(WIDTH - 1);

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_RUN  = 2'd1;
    localparam logic [1:0] C_ST_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_res_sh;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               r_borrow;
    logic [C_CNT_W-1:0] r_cnt;

    logic               w_accept;
    logic               w_run;
    logic               w_last;
    logic               w_x;
    logic               w_y;
    logic               w_d;
    logic               w_borrow_next;
    logic [WIDTH-1:0]   w_res_next;

    // A request is only honoured outside RUN; start during RUN is ignored.
    assign w_accept = start && (r_state != C_ST_RUN);
    assign w_run    = (r_state == C_ST_RUN);
    assign w_last   = w_run && (r_cnt == C_LAST);

    // One full-subtractor slice on the current LSBs.
    assign w_x           = r_a_sh[0];
    assign w_y           = r_b_sh[0];
    assign w_d           = w_x ^ w_y ^ r_borrow;
    assign w_borrow_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_borrow);

    // Result bits enter at the MSB so the LSB-first stream lands in place.
    generate
        if (WIDTH == 1) begin : g_res_narrow
            assign w_res_next = w_d;
        end else begin : g_res_wide
            assign w_res_next = {w_d, r_res_sh[WIDTH-1:1]};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: RUN lasts WIDTH cycles, DONE may restart directly.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            C_ST_IDLE: if (start) w_state_next = C_ST_RUN;
            C_ST_RUN:  if (r_cnt == C_LAST) w_state_next = C_ST_DONE;
            C_ST_DONE: w_state_next = start ? C_ST_RUN : C_ST_IDLE;
            default:   w_state_next = C_ST_IDLE;
        endcase
    end

    // Datapath: load operands on accept, then shift one bit per RUN cycle;
    // the visible result only changes on the final RUN edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
        end else if (w_accept) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else if (w_run) begin
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_res_sh <= w_res_next;
            r_borrow <= w_borrow_next;
            r_cnt    <= r_cnt + C_CNT_W'(1);
            if (w_last) begin
                r_diff <= w_res_next;
                r_bout <= w_borrow_next;
            end
        end
    end

    assign busy = (r_state == C_ST_RUN);
    assign done = (r_state == C_ST_DONE);
    assign diff = r_diff;
    assign bout = r_bout;

endmodule
`default_nettype wire

// File: tb/tb_serial_sub.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_serial_sub
// Description : Self-checking bench for serial_sub (WIDTH=8 and WIDTH=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_sub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, busy, done, bout;
    logic [W-1:0] a, b, diff;
    logic         start1, busy1, done1, bout1;
    logic [0:0]   a1, b1, diff1;

    always #5 clk = ~clk;

    serial_sub #(.WIDTH(W)) u_dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .bout(bout)
    );

    serial_sub #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
    );

    typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] diff; logic bout; } vec_t;
    typedef struct { logic [W-1:0] diff; logic bout; } exp_t;

    exp_t         sb[$];
    logic [1:0]   sb1[$];
    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] last_diff;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Issue one op at the current negedge and follow it to its done pulse.
    task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                          input exp_t e, input bit noisy);
        exp_t ex;
        int   n;
        int   nb;
        a = ai; b = bi; start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        n = 1; nb = 0;
        start = 1'b0;
        check("diff_hold_in_run", 32'(diff), 32'(last_diff));
        while (!done && n < 3 * W) begin
            if (!busy) nb++;
            if (noisy) begin
                a = W'($urandom);
                b = W'($urandom);
                start = (n < W);
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("busy_cycles_missing", 32'(nb), 32'(0));
        check("latency", 32'(n), 32'(W + 1));
        check("busy_with_done", 32'(busy), 32'(0));
        if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            ex = sb.pop_front();
            check("diff", 32'(diff), 32'(ex.diff));
            check("bout", 32'(bout), 32'(ex.bout));
            last_diff = ex.diff;
        end
    endtask

    task automatic idle_check();
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'(0));
        check("idle_not_busy", 32'(busy), 32'(0));
    endtask

    task automatic run1(input logic ai, input logic bi);
        logic [1:0] ex;
        int n;
        a1 = ai; b1 = bi; start1 = 1'b1;
        sb1.push_back({(ai < bi) ? 1'b1 : 1'b0, ai - bi});
        @(negedge clk);
        start1 = 1'b0;
        n = 1;
        while (!done1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("w1_latency", 32'(n), 32'(2));
        ex = sb1.pop_front();
        check("w1_diff", 32'(diff1), 32'(ex[0]));
        check("w1_bout", 32'(bout1), 32'(ex[1]));
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[8];
        exp_t e;
        int   nd;

        vt = '{
            '{8'd200, 8'd55,  8'd145, 1'b0},
            '{8'd55,  8'd200, 8'd111, 1'b1},
            '{8'd0,   8'd1,   8'd255, 1'b1},
            '{8'hAA,  8'hAA,  8'd0,   1'b0},
            '{8'd255, 8'd0,   8'd255, 1'b0},
            '{8'd0,   8'd255, 8'd1,   1'b1},
            '{8'd128, 8'd127, 8'd1,   1'b0},
            '{8'd1,   8'd0,   8'd1,   1'b0}
        };

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        start1 = 1'b0; a1 = '0; b1 = '0;
        last_diff = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_diff", 32'(diff), 32'(0));
        check("rst_bout", 32'(bout), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        // Table vectors; the AA-AA case also scrambles a/b and holds start in RUN.
        for (int i = 0; i < 8; i++) begin
            e.diff = vt[i].diff;
            e.bout = vt[i].bout;
            run_op(vt[i].a, vt[i].b, e, (i == 3));
            idle_check();
        end

        // Back-to-back: start while in DONE restarts immediately.
        e.diff = 8'd15; e.bout = 1'b0;
        run_op(8'd20, 8'd5, e, 1'b0);
        e.diff = 8'd7;  e.bout = 1'b0;
        run_op(8'd10, 8'd3, e, 1'b0);
        idle_check();

        // Asynchronous reset partway through RUN aborts with no done pulse.
        a = 8'd77; b = 8'd12; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_diff", 32'(diff), 32'(0));
        check("abort_bout", 32'(bout), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        last_diff = '0;
        nd = 0;
        repeat (W + 3) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("abort_no_done", 32'(nd), 32'(0));
        e.diff = 8'd5; e.bout = 1'b0;
        run_op(8'd9, 8'd4, e, 1'b0);
        idle_check();

        // WIDTH=1: exhaustive half-subtractor.
        for (int i = 0; i < 4; i++) begin
            run1(i[1], i[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
